// File: rtl/hash_table_host.sv
// Host-side initiator for the pin-level hash-table command protocol.
// Sequences setup, go, busy-wait with timeout, response hand-off and inter-request gap.
module hash_table_host #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned GO_LAT       = 2,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [3:0] req_key,
  input  logic [3:0] req_val,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_status,
  output logic [3:0] rsp_out,
  output logic       rsp_timeout,
  output logic [3:0] dev_key,
  output logic [3:0] dev_val,
  output logic [1:0] dev_cmd,
  output logic       dev_go,
  input  logic [1:0] dev_status,
  input  logic [3:0] dev_out
);

  localparam int unsigned CMAX_A = (SETUP_CYCLES > GO_LAT) ? SETUP_CYCLES : GO_LAT;
  localparam int unsigned CMAX   = (CMAX_A > GAP_CYCLES) ? CMAX_A : GAP_CYCLES;
  localparam int unsigned CW     = (CMAX > 2) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, ARM, WAIT, RESP, GAP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    tcnt, tcnt_d;
  logic [1:0]    status_q;
  logic [3:0]    out_q;
  logic          go_d;
  logic          accept;
  logic          capture;
  logic          cap_timeout;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    tcnt_d      = tcnt;
    go_d        = dev_go;
    capture     = 1'b0;
    cap_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_d   = CW'(SETUP_CYCLES - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          go_d    = 1'b1;
          cnt_d   = CW'(GO_LAT - 1);
          state_d = ARM;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      ARM: begin
        if (cnt == '0) begin
          tcnt_d  = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      WAIT: begin
        // Status 3 means the device is still busy; a stuck device is bounded by TIMEOUT.
        if (status_q != 2'd3) begin
          capture = 1'b1;
          go_d    = 1'b0;
          state_d = RESP;
        end else if (tcnt == 8'(TIMEOUT - 1)) begin
          capture     = 1'b1;
          cap_timeout = 1'b1;
          go_d        = 1'b0;
          state_d     = RESP;
        end else begin
          tcnt_d = tcnt + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          cnt_d   = CW'(GAP_CYCLES - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      tcnt        <= '0;
      status_q    <= 2'd3;
      out_q       <= '0;
      dev_go      <= 1'b0;
      dev_key     <= '0;
      dev_val     <= '0;
      dev_cmd     <= '0;
      rsp_status  <= '0;
      rsp_out     <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      tcnt     <= tcnt_d;
      status_q <= dev_status;
      out_q    <= dev_out;
      dev_go   <= go_d;
      if (accept) begin
        dev_key <= req_key;
        dev_val <= req_val;
        dev_cmd <= req_cmd;
      end
      if (capture) begin
        rsp_status  <= cap_timeout ? 2'd3 : status_q;
        rsp_out     <= out_q;
        rsp_timeout <= cap_timeout;
      end
    end
  end

endmodule
